// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the pc_sequencer call/return controller.
package pc_seq_pkg;

  localparam int AW_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    XFER = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for pc_sequencer; storage is not reset, top reads 0 when empty.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                push_addr,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [AW-1:0]                top
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  // A full stack wraps wr_idx to 0, which is why rd_idx = wr_idx - 1 still hits the last entry.
  always_comb begin
    wr_idx  = depth_q[IW-1:0];
    rd_idx  = wr_idx - 1'b1;
    full    = (depth_q == DW'(DEPTH));
    empty   = (depth_q == '0);
    do_push = push && !full && !clear;
    do_pop  = pop && !empty && !clear;
    depth_d = depth_q;
    if (clear) begin
      depth_d = '0;
    end else if (do_push) begin
      depth_d = depth_q + 1'b1;
    end else if (do_pop) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    depth_q <= depth_d;
    if (do_push) begin
      mem_q[wr_idx] <= push_addr;
    end
  end

  assign depth = depth_q;
  assign top   = empty ? '0 : mem_q[rd_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Call/return program-counter sequencer with a return stack.
// Define PC_SEQ_CYCCNT_EN to add the saturating cyc_cnt busy-cycle counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       start,
  input  logic                       go,
  input  logic                       halt,
  input  logic                       call,
  input  logic                       ret,
  input  logic [AW-1:0]              target,
  input  logic [AW-1:0]              rp,
  output logic                       jump2sub,
  output logic [AW-1:0]              subroutine,
  output logic                       pc_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] depth
`ifdef PC_SEQ_CYCCNT_EN
  ,
  output logic [15:0]                cyc_cnt
`endif
);

  state_e        state_q, state_d;
  logic          jump2sub_q, jump2sub_d;
  logic [AW-1:0] subroutine_q, subroutine_d;
  logic          pc_en_q, pc_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          stk_push, stk_pop, stk_clear, stk_full, stk_empty;
  logic [AW-1:0] stk_top, ret_addr;

  assign ret_addr = rp + 1'b1;

  ret_stack #(.DEPTH(DEPTH), .AW(AW)) u_stack (
    .clk       (clk),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_addr (ret_addr),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (depth),
    .top       (stk_top)
  );

  // Outputs are decoded from the next state so they appear registered in the same cycle as the state.
  always_comb begin
    state_d      = state_q;
    subroutine_d = subroutine_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_clear    = 1'b0;
    case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (ret) begin
          if (stk_empty) begin
            state_d = ERR;
          end else begin
            stk_pop      = 1'b1;
            subroutine_d = stk_top;
            state_d      = XFER;
          end
        end else if (call) begin
          if (stk_full) begin
            state_d = ERR;
          end else begin
            stk_push     = 1'b1;
            subroutine_d = target;
            state_d      = XFER;
          end
        end
      end
      XFER: state_d = RUN;
      DONE: begin
        if (go) begin
          stk_clear = 1'b1;
          state_d   = RUN;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d   = IDLE;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clear = 1'b1;
    end
    jump2sub_d = (state_d == XFER);
    pc_en_d    = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == XFER);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q      <= IDLE;
      jump2sub_q   <= 1'b0;
      subroutine_q <= '0;
      pc_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      jump2sub_q   <= jump2sub_d;
      subroutine_q <= subroutine_d;
      pc_en_q      <= pc_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign jump2sub   = jump2sub_q;
  assign subroutine = subroutine_q;
  assign pc_en      = pc_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef PC_SEQ_CYCCNT_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  // A fresh run starts counting from zero; time spent in DONE or ERR is not counted.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (((state_q == IDLE) || (state_q == DONE)) && go) begin
      cyc_cnt_d = '0;
    end else if (((state_q == RUN) || (state_q == XFER)) && (cyc_cnt_q != 16'hFFFF)) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based behavioural model.
// Define PC_SEQ_CYCCNT_EN to also exercise the cyc_cnt counter.
module tb_pc_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk;
  logic          start, go, halt, call, ret;
  logic [AW-1:0] target, rp;
  logic          jump2sub, pc_en, busy, done, err;
  logic [AW-1:0] subroutine;
  logic [2:0]    depth;
`ifdef PC_SEQ_CYCCNT_EN
  logic [15:0]   cyc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  string       mode;
  int unsigned stk[$];
  int unsigned exp_sub;
  int unsigned exp_cyc;

  pc_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .start      (start),
    .go         (go),
    .halt       (halt),
    .call       (call),
    .ret        (ret),
    .target     (target),
    .rp         (rp),
    .jump2sub   (jump2sub),
    .subroutine (subroutine),
    .pc_en      (pc_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .depth      (depth)
`ifdef PC_SEQ_CYCCNT_EN
    ,
    .cyc_cnt    (cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural model: one call per clock edge, using the inputs currently driven.
  task automatic modelStep();
    string prev;
    prev = mode;
    if (start) begin
      mode = "IDLE";
      stk.delete();
      exp_sub = 0;
      exp_cyc = 0;
      return;
    end
    case (mode)
      "IDLE": if (go) mode = "RUN";
      "RUN": begin
        if (halt) mode = "DONE";
        else if (ret) begin
          if (stk.size() == 0) mode = "ERR";
          else begin
            exp_sub = stk.pop_back();
            mode = "XFER";
          end
        end else if (call) begin
          if (stk.size() == DEPTH) mode = "ERR";
          else begin
            stk.push_back((int'(rp) + 1) % (1 << AW));
            exp_sub = int'(target);
            mode = "XFER";
          end
        end
      end
      "XFER": mode = "RUN";
      "DONE": if (go) begin
        stk.delete();
        mode = "RUN";
      end
      default: mode = mode;
    endcase
    if ((prev == "IDLE" || prev == "DONE") && go) exp_cyc = 0;
    else if ((prev == "RUN" || prev == "XFER") && exp_cyc < 65535) exp_cyc++;
  endtask

  task automatic applyStimulus(input logic s, input logic g, input logic h, input logic c,
                               input logic r, input logic [AW-1:0] tgt, input logic [AW-1:0] pc);
    start  = s;
    go     = g;
    halt   = h;
    call   = c;
    ret    = r;
    target = tgt;
    rp     = pc;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".jump2sub"},   32'(jump2sub),   32'(mode == "XFER"));
    checkVal({tag, ".pc_en"},      32'(pc_en),      32'(mode == "RUN"));
    checkVal({tag, ".busy"},       32'(busy),       32'(mode == "RUN" || mode == "XFER"));
    checkVal({tag, ".done"},       32'(done),       32'(mode == "DONE"));
    checkVal({tag, ".err"},        32'(err),        32'(mode == "ERR"));
    checkVal({tag, ".subroutine"}, 32'(subroutine), exp_sub);
    checkVal({tag, ".depth"},      32'(depth),      32'(stk.size()));
`ifdef PC_SEQ_CYCCNT_EN
    checkVal({tag, ".cyc_cnt"},    32'(cyc_cnt),    exp_cyc);
`endif
  endtask

  task automatic step(input string tag, input logic s, input logic g, input logic h, input logic c,
                      input logic r, input logic [AW-1:0] tgt, input logic [AW-1:0] pc);
    applyStimulus(s, g, h, c, r, tgt, pc);
    checkOutput(tag);
  endtask

  initial begin
    mode    = "IDLE";
    exp_sub = 0;
    exp_cyc = 0;

    // Reset held two cycles, then idle.
    step("rst0", 1, 0, 0, 0, 0, '0, '0);
    step("rst1", 1, 0, 0, 0, 0, '0, '0);
    step("idle", 0, 0, 0, 0, 0, '0, '0);
    checkVal("idle_pc_en", 32'(pc_en), 32'd0);

    step("go", 0, 1, 0, 0, 0, '0, '0);
    checkVal("go_pc_en", 32'(pc_en), 32'd1);

    // Simple call then return.
    step("call", 0, 0, 0, 1, 0, 10'h100, 10'h020);
    checkVal("call_sub", 32'(subroutine), 32'h100);
    checkVal("call_depth", 32'(depth), 32'd1);
    step("call_xfer_end", 0, 0, 0, 0, 0, '0, '0);
    step("ret", 0, 0, 0, 0, 1, '0, 10'h105);
    checkVal("ret_sub", 32'(subroutine), 32'h021);
    step("ret_xfer_end", 0, 0, 0, 0, 0, '0, '0);

    // Call held high fills the stack from rp=3FF; XFER cycles ignore it.
    for (int i = 0; i < 8; i++) step("nest", 0, 0, 0, 1, 0, AW'(i * 16 + 1), 10'h3FF);
    checkVal("nest_depth", 32'(depth), 32'd4);
    step("ret_wrap", 0, 0, 0, 0, 1, '0, 10'h123);
    checkVal("ret_wrap_sub", 32'(subroutine), 32'h000);
    step("ret_wrap_end", 0, 0, 0, 0, 0, '0, '0);
    step("refill", 0, 0, 0, 1, 0, 10'h055, 10'h3FF);
    step("refill_end", 0, 0, 0, 0, 0, '0, '0);
    step("overflow", 0, 0, 0, 1, 0, 10'h077, 10'h3FF);
    checkVal("overflow_err", 32'(err), 32'd1);
    checkVal("overflow_depth", 32'(depth), 32'd4);
    step("err_go", 0, 1, 0, 0, 0, '0, '0);
    step("err_clear", 1, 0, 0, 0, 0, '0, '0);
    checkVal("err_cleared", 32'(err), 32'd0);

    // Underflow.
    step("uf_go", 0, 1, 0, 0, 0, '0, '0);
    step("underflow", 0, 0, 0, 0, 1, '0, 10'h010);
    checkVal("underflow_err", 32'(err), 32'd1);

    // Halt wins over call and ret; go from DONE clears the stack.
    step("h_rst", 1, 0, 0, 0, 0, '0, '0);
    step("h_go", 0, 1, 0, 0, 0, '0, '0);
    step("h_call", 0, 0, 0, 1, 0, 10'h200, 10'h0AA);
    step("h_xfer", 0, 0, 0, 0, 0, '0, '0);
    step("halt_all", 0, 0, 1, 1, 1, 10'h300, 10'h0BB);
    checkVal("halt_done", 32'(done), 32'd1);
    checkVal("halt_depth", 32'(depth), 32'd1);
    step("done_go", 0, 1, 0, 0, 0, '0, '0);
    checkVal("done_go_depth", 32'(depth), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           AW'($urandom),
           AW'($urandom));
    end

`ifdef PC_SEQ_CYCCNT_EN
    step("cc_rst", 1, 0, 0, 0, 0, '0, '0);
    step("cc_go", 0, 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 0, 0, 0, '0, '0);
    checkOutput("cc_sat");
    checkVal("cc_sat_value", 32'(cyc_cnt), 32'hFFFF);
    step("cc_call", 0, 0, 0, 1, 0, 10'h111, 10'h010);
    step("cc_start_xfer", 1, 0, 0, 0, 0, '0, '0);
    checkVal("cc_start_j2s", 32'(jump2sub), 32'd0);
    checkVal("cc_start_cnt", 32'(cyc_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
